// File: rtl/canvas_draw_scheduler.sv
// Canvas write-port scheduler: turns brush-stamp and full-clear requests into one registered pixel write per clock.
// Optional CLEAR_PREEMPT_EN lets a clear request abort a stamp in progress.
module canvas_draw_scheduler #(
  parameter int COLOR_BITS = 2,
  parameter int WIDTH      = 100,
  parameter int HEIGHT     = 100,
  parameter int BRUSH      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stamp_req,
  input  logic [9:0]            stamp_x,
  input  logic [9:0]            stamp_y,
  input  logic [COLOR_BITS-1:0] stamp_color,
  input  logic                  clear_req,
  input  logic [COLOR_BITS-1:0] clear_color,
  output logic                  stamp_ack,
  output logic                  clear_ack,
  output logic                  busy,
  output logic                  done,
  output logic [9:0]            writeX,
  output logic [9:0]            writeY,
  output logic                  write_enable,
  output logic [COLOR_BITS-1:0] write_color
);

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  localparam logic [10:0] WIDTH_11  = 11'(WIDTH);
  localparam logic [10:0] HEIGHT_11 = 11'(HEIGHT);
  localparam logic [9:0]  CLR_LAST_X = 10'(WIDTH - 1);
  localparam logic [9:0]  CLR_LAST_Y = 10'(HEIGHT - 1);
  localparam logic [9:0]  STP_LAST   = 10'(BRUSH - 1);

  state_t                  state, state_d;
  logic [9:0]              x0, y0, cnt_x, cnt_y;
  logic [COLOR_BITS-1:0]   color_q;
  logic                    fin;      // every pixel of the operation has been issued

  logic                    abort, issuing, at_end, row_end;
  logic [9:0]              last_x, last_y;
  logic [10:0]             sum_x, sum_y;
  logic                    stamp_ack_d, clear_ack_d, busy_d, done_d, we_d;
  logic [9:0]              write_x_d, write_y_d;
  logic [COLOR_BITS-1:0]   write_color_d;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      x0           <= '0;
      y0           <= '0;
      cnt_x        <= '0;
      cnt_y        <= '0;
      color_q      <= '0;
      fin          <= 1'b0;
      stamp_ack    <= 1'b0;
      clear_ack    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      write_enable <= 1'b0;
      writeX       <= '0;
      writeY       <= '0;
      write_color  <= '0;
    end else begin
      state        <= state_d;
      stamp_ack    <= stamp_ack_d;
      clear_ack    <= clear_ack_d;
      busy         <= busy_d;
      done         <= done_d;
      write_enable <= we_d;
      writeX       <= write_x_d;
      writeY       <= write_y_d;
      write_color  <= write_color_d;
      if (clear_ack_d) begin
        color_q <= clear_color;
        cnt_x   <= '0;
        cnt_y   <= '0;
        fin     <= 1'b0;
      end else if (stamp_ack_d) begin
        x0      <= stamp_x;
        y0      <= stamp_y;
        color_q <= stamp_color;
        cnt_x   <= '0;
        cnt_y   <= '0;
        fin     <= 1'b0;
      end else if (issuing) begin
        fin <= at_end;
        if (row_end) begin
          cnt_x <= '0;
          cnt_y <= cnt_y + 10'd1;
        end else begin
          cnt_x <= cnt_x + 10'd1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state;
`ifdef CLEAR_PREEMPT_EN
    abort = (state == STAMP) && clear_req;
`else
    abort = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (clear_req)      state_d = CLEAR;
        else if (stamp_req) state_d = STAMP;
      end
      STAMP: begin
        if (abort)    state_d = CLEAR;
        else if (fin) state_d = IDLE;
      end
      CLEAR: begin
        if (fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic; values here are registered on the next edge.
  always_comb begin
    last_x  = (state == CLEAR) ? CLR_LAST_X : STP_LAST;
    last_y  = (state == CLEAR) ? CLR_LAST_Y : STP_LAST;
    row_end = (cnt_x == last_x);
    at_end  = row_end && (cnt_y == last_y);
    issuing = (state != IDLE) && !fin && !abort;

    // Stamp coordinates are summed in 11 bits so an off-canvas pixel can never alias onto the canvas.
    sum_x = (state == STAMP) ? ({1'b0, x0} + {1'b0, cnt_x}) : {1'b0, cnt_x};
    sum_y = (state == STAMP) ? ({1'b0, y0} + {1'b0, cnt_y}) : {1'b0, cnt_y};

    stamp_ack_d   = (state == IDLE) && !clear_req && stamp_req;
    clear_ack_d   = ((state == IDLE) && clear_req) || abort;
    busy_d        = issuing;
    done_d        = (state != IDLE) && fin && !abort;
    we_d          = issuing && (sum_x < WIDTH_11) && (sum_y < HEIGHT_11);
    write_x_d     = issuing ? sum_x[9:0] : writeX;
    write_y_d     = issuing ? sum_y[9:0] : writeY;
    write_color_d = issuing ? color_q : write_color;
  end

endmodule
